// File: rtl/sc_posjug2_control.sv
// ---------------------------------------------------------------------------
// sc_posjug2_control
//
// Player-2 position controller. Two raw active-low push buttons move a
// one-hot position left (toward the MSB) or right (toward the LSB). A button
// held down auto-repeats the move every POSJUG2_REPEAT+1 cycles. At the ends
// of the row a move is refused and reported instead of wrapping around.
//
// Ports
//   SC_POSJUG2_CLOCK_50        in   system clock, rising-edge active
//   SC_POSJUG2_RESET_InHigh    in   asynchronous reset, active high
//   SC_POSJUG2_left_InLow      in   raw move-left button, active low
//   SC_POSJUG2_right_InLow     in   raw move-right button, active low
//   SC_POSJUG2_enable_InHigh   in   game running; low inhibits movement
//   SC_POSJUG2_clear_InHigh    in   synchronous return to POSJUG2_INITPOS
//   SC_POSJUG2_OutBUS          out  registered one-hot position
//   SC_POSJUG2_step_OutHigh    out  one-cycle pulse when the position moves
//   SC_POSJUG2_blocked_OutHigh out  one-cycle pulse when a move is refused
// ---------------------------------------------------------------------------
module sc_posjug2_control #(
  parameter int                           POSJUG2_DATAWIDTH = 8,
  parameter logic [POSJUG2_DATAWIDTH-1:0] POSJUG2_INITPOS   = 8'b0001_0000,
  parameter logic [23:0]                  POSJUG2_REPEAT    = 24'd6_250_000
) (
  input  logic                         SC_POSJUG2_CLOCK_50,
  input  logic                         SC_POSJUG2_RESET_InHigh,
  input  logic                         SC_POSJUG2_left_InLow,
  input  logic                         SC_POSJUG2_right_InLow,
  input  logic                         SC_POSJUG2_enable_InHigh,
  input  logic                         SC_POSJUG2_clear_InHigh,
  output logic [POSJUG2_DATAWIDTH-1:0] SC_POSJUG2_OutBUS,
  output logic                         SC_POSJUG2_step_OutHigh,
  output logic                         SC_POSJUG2_blocked_OutHigh
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    HOLD = 2'd2
  } stateT;

  localparam logic DIR_LEFT  = 1'b0;  // toward MSB
  localparam logic DIR_RIGHT = 1'b1;  // toward LSB

  // HOLD counts down from REPEAT-1 to 0 and then spends one more cycle
  // deciding, so together with STEP the repeat period is REPEAT+1 cycles.
  localparam logic [23:0] CNT_RELOAD = POSJUG2_REPEAT - 24'd1;

  // Bit 0 = left button, bit 1 = right button (raw, active low).
  logic [1:0] rawButtons;
  logic [1:0] syncStage1Reg;
  logic [1:0] syncStage2Reg;

  logic leftPress;
  logic rightPress;

  stateT                        stateReg;
  logic                         dirReg;
  logic [23:0]                  cntReg;
  logic [POSJUG2_DATAWIDTH-1:0] posReg;
  logic                         stepReg;
  logic                         blockedReg;

  logic                         atEdge;
  logic [POSJUG2_DATAWIDTH-1:0] shiftedPos;
  logic                         dirHeld;
  logic                         oppositeHeld;

  assign rawButtons = {SC_POSJUG2_right_InLow, SC_POSJUG2_left_InLow};

  // Two-flop synchronizer. Reset value is 1 so a button reads as released
  // until its real level has crossed both stages.
  always_ff @(posedge SC_POSJUG2_CLOCK_50 or posedge SC_POSJUG2_RESET_InHigh) begin
    if (SC_POSJUG2_RESET_InHigh) begin
      syncStage1Reg <= 2'b11;
      syncStage2Reg <= 2'b11;
    end else begin
      syncStage1Reg <= rawButtons;
      syncStage2Reg <= syncStage1Reg;
    end
  end

  assign leftPress  = ~syncStage2Reg[0];
  assign rightPress = ~syncStage2Reg[1];

  // Move evaluation for the current direction. A one-hot value at the end
  // bit in the direction of travel cannot move without wrapping.
  always_comb begin
    atEdge       = 1'b0;
    shiftedPos   = posReg;
    dirHeld      = 1'b0;
    oppositeHeld = 1'b0;
    if (dirReg == DIR_LEFT) begin
      atEdge       = posReg[POSJUG2_DATAWIDTH-1];
      shiftedPos   = posReg << 1;
      dirHeld      = leftPress;
      oppositeHeld = rightPress;
    end else begin
      atEdge       = posReg[0];
      shiftedPos   = posReg >> 1;
      dirHeld      = rightPress;
      oppositeHeld = leftPress;
    end
  end

  // Control FSM with registered position and pulse outputs.
  always_ff @(posedge SC_POSJUG2_CLOCK_50 or posedge SC_POSJUG2_RESET_InHigh) begin
    if (SC_POSJUG2_RESET_InHigh) begin
      stateReg   <= IDLE;
      dirReg     <= DIR_LEFT;
      cntReg     <= 24'd0;
      posReg     <= POSJUG2_INITPOS;
      stepReg    <= 1'b0;
      blockedReg <= 1'b0;
    end else begin
      stepReg    <= 1'b0;
      blockedReg <= 1'b0;
      if (SC_POSJUG2_clear_InHigh) begin
        // Clear overrides everything, including a move in flight.
        stateReg <= IDLE;
        cntReg   <= 24'd0;
        posReg   <= POSJUG2_INITPOS;
      end else begin
        case (stateReg)
          IDLE: begin
            if (SC_POSJUG2_enable_InHigh && leftPress && !rightPress) begin
              dirReg   <= DIR_LEFT;
              stateReg <= STEP;
            end else if (SC_POSJUG2_enable_InHigh && rightPress && !leftPress) begin
              dirReg   <= DIR_RIGHT;
              stateReg <= STEP;
            end
          end

          STEP: begin
            // The move always completes; a dropped enable only prevents
            // entering the repeat phase.
            if (atEdge) begin
              blockedReg <= 1'b1;
            end else begin
              posReg  <= shiftedPos;
              stepReg <= 1'b1;
            end
            cntReg   <= CNT_RELOAD;
            stateReg <= SC_POSJUG2_enable_InHigh ? HOLD : IDLE;
          end

          HOLD: begin
            if (!SC_POSJUG2_enable_InHigh || !dirHeld || oppositeHeld) begin
              stateReg <= IDLE;
            end else if (cntReg == 24'd0) begin
              stateReg <= STEP;
            end else begin
              cntReg <= cntReg - 24'd1;
            end
          end

          default: stateReg <= IDLE;
        endcase
      end
    end
  end

  assign SC_POSJUG2_OutBUS          = posReg;
  assign SC_POSJUG2_step_OutHigh    = stepReg;
  assign SC_POSJUG2_blocked_OutHigh = blockedReg;

endmodule

// File: tb/tb_sc_posjug2_control.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_sc_posjug2_control
//
// Scoreboard bench: each scenario pushes the expected step/blocked events
// (position, kind, edge number) when it drives the buttons; a negedge monitor
// pops and compares every pulse the design produces. Pulses with nothing
// expected are flagged, and leftover expectations are flagged at scenario end.
// ---------------------------------------------------------------------------
module tb_sc_posjug2_control;

  localparam int          W      = 8;
  localparam logic [23:0] REPEAT = 24'd4;

  logic         clk;
  logic         rst;
  logic         leftN;
  logic         rightN;
  logic         enable;
  logic         clear;
  logic [W-1:0] pos;
  logic         step;
  logic         blocked;

  sc_posjug2_control #(
    .POSJUG2_DATAWIDTH(W),
    .POSJUG2_INITPOS  (8'b0001_0000),
    .POSJUG2_REPEAT   (REPEAT)
  ) dut (
    .SC_POSJUG2_CLOCK_50       (clk),
    .SC_POSJUG2_RESET_InHigh   (rst),
    .SC_POSJUG2_left_InLow     (leftN),
    .SC_POSJUG2_right_InLow    (rightN),
    .SC_POSJUG2_enable_InHigh  (enable),
    .SC_POSJUG2_clear_InHigh   (clear),
    .SC_POSJUG2_OutBUS         (pos),
    .SC_POSJUG2_step_OutHigh   (step),
    .SC_POSJUG2_blocked_OutHigh(blocked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edgeCount = 0;
  always @(posedge clk) edgeCount <= edgeCount + 1;

  int checkCount = 0;
  int failCount  = 0;

  task automatic checkVal(input string tag, input logic [31:0] actual,
                          input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", tag, actual, expected, $time);
    end else begin
      $display("ok   %s value=%0h", tag, actual);
    end
  endtask

  typedef struct {
    string        tag;
    logic [W-1:0] pos;
    logic         isBlocked;
    int           edgeNo;
  } expT;

  expT expQ[$];

  task automatic pushExp(input string tag, input logic [W-1:0] p,
                         input logic blk, input int edgeNo);
    expT e;
    e.tag       = tag;
    e.pos       = p;
    e.isBlocked = blk;
    e.edgeNo    = edgeNo;
    expQ.push_back(e);
  endtask

  task automatic waitNeg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    expT e;
    if (!rst && (step || blocked)) begin
      if (expQ.size() == 0) begin
        checkVal("stray_pulse", {30'd0, step, blocked}, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkVal({e.tag, "_pos"}, pos, e.pos);
        checkVal({e.tag, "_kind"}, {30'd0, step, blocked},
                 e.isBlocked ? 32'd1 : 32'd2);
        checkVal({e.tag, "_edge"}, edgeCount, e.edgeNo);
        checkVal({e.tag, "_onehot"}, {31'd0, $onehot(pos)}, 32'd1);
      end
    end
  end

  task automatic doClear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checkVal("clear_pos", pos, 8'b0001_0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checkCount);
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    int e;
    rst    = 1'b1;
    leftN  = 1'b1;
    rightN = 1'b1;
    enable = 1'b0;
    clear  = 1'b0;
    #1;
    checkVal("reset_pos", pos, 8'b0001_0000);
    checkVal("reset_step", {31'd0, step}, 32'd0);
    checkVal("reset_blocked", {31'd0, blocked}, 32'd0);
    waitNeg(3);
    rst    = 1'b0;
    enable = 1'b1;
    waitNeg(3);
    checkVal("idle_pos", pos, 8'b0001_0000);

    // Single press of right, 3 samples low.
    @(negedge clk);
    d = edgeCount;
    rightN = 1'b0;
    pushExp("single", 8'b0000_1000, 1'b0, d + 4);
    waitNeg(3);
    rightN = 1'b1;
    waitNeg(10);
    checkVal("single_left", expQ.size(), 0);
    checkVal("single_pos", pos, 8'b0000_1000);

    // Held left with auto-repeat up to the MSB, then a refused move.
    doClear();
    @(negedge clk);
    d = edgeCount;
    leftN = 1'b0;
    pushExp("hold1", 8'b0010_0000, 1'b0, d + 4);
    pushExp("hold2", 8'b0100_0000, 1'b0, d + 9);
    pushExp("hold3", 8'b1000_0000, 1'b0, d + 14);
    pushExp("holdblk", 8'b1000_0000, 1'b1, d + 19);
    waitNeg(20);
    leftN = 1'b1;
    waitNeg(20);
    checkVal("hold_left", expQ.size(), 0);
    checkVal("hold_pos", pos, 8'b1000_0000);

    // Both buttons together: nothing moves.
    @(negedge clk);
    leftN  = 1'b0;
    rightN = 1'b0;
    waitNeg(15);
    leftN  = 1'b1;
    rightN = 1'b1;
    waitNeg(10);
    checkVal("both_pos", pos, 8'b1000_0000);

    // Clear while in HOLD at position 0000_0010.
    doClear();
    @(negedge clk);
    d = edgeCount;
    rightN = 1'b0;
    pushExp("toTwo1", 8'b0000_1000, 1'b0, d + 4);
    pushExp("toTwo2", 8'b0000_0100, 1'b0, d + 9);
    pushExp("toTwo3", 8'b0000_0010, 1'b0, d + 14);
    waitNeg(15);
    rightN = 1'b1;
    checkVal("preclear_pos", pos, 8'b0000_0010);
    waitNeg(1);
    clear = 1'b1;
    waitNeg(1);
    clear = 1'b0;
    checkVal("holdclear_pos", pos, 8'b0001_0000);
    waitNeg(10);
    checkVal("holdclear_left", expQ.size(), 0);
    checkVal("holdclear_stay", pos, 8'b0001_0000);
    @(negedge clk);
    d = edgeCount;
    rightN = 1'b0;
    pushExp("fresh", 8'b0000_1000, 1'b0, d + 4);
    waitNeg(3);
    rightN = 1'b1;
    waitNeg(8);
    checkVal("fresh_left", expQ.size(), 0);

    // Enable drops while right is held, then returns with it still held.
    @(negedge clk);
    d = edgeCount;
    rightN = 1'b0;
    pushExp("en1", 8'b0000_0100, 1'b0, d + 4);
    waitNeg(6);
    enable = 1'b0;
    waitNeg(12);
    checkVal("endrop_pos", pos, 8'b0000_0100);
    e = edgeCount;
    enable = 1'b1;
    pushExp("en2", 8'b0000_0010, 1'b0, e + 2);
    pushExp("en3", 8'b0000_0001, 1'b0, e + 7);
    waitNeg(8);
    rightN = 1'b1;
    waitNeg(10);
    checkVal("en_left", expQ.size(), 0);

    // Asynchronous reset in HOLD, right after a step pulse.
    @(negedge clk);
    d = edgeCount;
    leftN = 1'b0;
    pushExp("pre_rst", 8'b0000_0010, 1'b0, d + 4);
    waitNeg(4);
    #1;
    rst = 1'b1;
    #1;
    checkVal("arst_pos", pos, 8'b0001_0000);
    checkVal("arst_step", {31'd0, step}, 32'd0);
    checkVal("arst_blocked", {31'd0, blocked}, 32'd0);
    leftN = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    waitNeg(8);
    checkVal("arst_left", expQ.size(), 0);
    checkVal("arst_stay", pos, 8'b0001_0000);

    // Normal operation after reset release.
    @(negedge clk);
    d = edgeCount;
    leftN = 1'b0;
    pushExp("post_rst", 8'b0010_0000, 1'b0, d + 4);
    waitNeg(3);
    leftN = 1'b1;
    waitNeg(10);
    checkVal("post_left", expQ.size(), 0);
    checkVal("post_pos", pos, 8'b0010_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/sc_posjug2_control.md
SC_POSJUG2_CONTROL -- requirements
Module: SC_POSJUG2_CONTROL

Interface
REQ-001 SHALL have parameter POSJUG2_DATAWIDTH, default 8, the width of the one-hot position bus matching the row width used by the player-2 position comparator.
REQ-002 SHALL have parameter POSJUG2_INITPOS, default 8'b0001_0000, the one-hot position loaded at reset and clear.
REQ-003 SHALL have parameter POSJUG2_REPEAT, default 24'd6_250_000, the number of HOLD cycles between auto-repeat steps; valid values are >= 1.
REQ-004 SHALL have port SC_POSJUG2_CLOCK_50, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-005 SHALL have port SC_POSJUG2_RESET_InHigh, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have port SC_POSJUG2_left_InLow, input, 1 bit, raw asynchronous move-left button, active low.
REQ-007 SHALL have port SC_POSJUG2_right_InLow, input, 1 bit, raw asynchronous move-right button, active low.
REQ-008 SHALL have port SC_POSJUG2_enable_InHigh, input, 1 bit, game running; when low, movement is inhibited.
REQ-009 SHALL have port SC_POSJUG2_clear_InHigh, input, 1 bit, synchronous return to the initial position.
REQ-010 SHALL have port SC_POSJUG2_OutBUS, output, POSJUG2_DATAWIDTH bits, registered one-hot player-2 position, which is the posjug2 operand of the comparator stage.
REQ-011 SHALL have port SC_POSJUG2_step_OutHigh, output, 1 bit, one-cycle pulse when OutBUS changes.
REQ-012 SHALL have port SC_POSJUG2_blocked_OutHigh, output, 1 bit, one-cycle pulse when a step is refused at an edge.

Function
REQ-013 SHALL pass each button through a 2-flop synchronizer; the FSM sees only the synchronized, inverted (active-high) versions L and R.
REQ-014 SHALL implement the FSM states IDLE, STEP and HOLD, together with a direction register DIR (LEFT = toward MSB, RIGHT = toward LSB) and a down-counter CNT of width 24.
REQ-015 SHALL, in IDLE, transition to STEP with DIR=LEFT when enable=1, L=1 and R=0, and with DIR=RIGHT when enable=1, R=1 and L=0; otherwise it SHALL remain in IDLE.
REQ-016 SHALL, in STEP, execute one move, load CNT with POSJUG2_REPEAT-1, and go to HOLD; STEP lasts exactly 1 cycle.
REQ-017 SHALL define a move as follows: if the target bit is inside the range, OutBUS shifts by one position toward DIR and step_OutHigh=1 for that cycle.
REQ-018 SHALL NOT shift OutBUS when it is at bit W-1 with DIR=LEFT, or at bit 0 with DIR=RIGHT; instead blocked_OutHigh=1 for that cycle, with no wrap-around.
REQ-019 SHALL, in HOLD, go to IDLE if enable=0, if the DIR button is released, or if the opposite button is asserted.
REQ-020 SHALL, in HOLD when REQ-019 does not apply, go to STEP if CNT=0 and otherwise decrement CNT.
REQ-021 SHALL, while a button is held, produce auto-repeat steps every POSJUG2_REPEAT+1 cycles.
REQ-022 SHALL have a latency of 4 rising edges from the edge that first samples a raw button low to the OutBUS update: synchronizer stage 1, synchronizer stage 2, IDLE->STEP, and the STEP update.
REQ-023 SHALL give clear=1 priority over all FSM activity; on that edge it loads OutBUS=POSJUG2_INITPOS, sets state=IDLE and CNT=0, and drives no step or blocked pulse.
REQ-024 SHALL abort a STEP or HOLD if enable falls during it; OutBUS holds its value and the FSM goes to IDLE on the next edge, while a STEP already in progress completes its move.
REQ-025 SHALL never allow OutBUS to have other than exactly one bit set.

Reset
REQ-026 SHALL, while RESET_InHigh=1, asynchronously force OutBUS=POSJUG2_INITPOS, state=IDLE, DIR=LEFT, CNT=0, synchronizer flops=1 (released), step_OutHigh=0 and blocked_OutHigh=0.
REQ-027 SHALL, when reset is asserted mid-HOLD or mid-STEP, abandon the move without any partial update; after release the FSM starts from IDLE and requires the synchronized button level.

Verification (POSJUG2_REPEAT=4, W=8)
REQ-028 SHALL cover a single press: reset, enable=1, right held low for 3 cycles -> OutBUS 0001_0000 -> 0000_1000 exactly 4 edges after first low sample; one step pulse.
REQ-029 SHALL cover a held button: left held low for 20 cycles from 0001_0000 -> steps at edges 4, 9 and 14, giving 0010_0000, 0100_0000, 1000_0000; the next repeat gives a blocked pulse with OutBUS unchanged.
REQ-030 SHALL cover both buttons: left and right pressed on the same cycle -> no step or blocked pulse, and OutBUS unchanged indefinitely.
REQ-031 SHALL cover clear during HOLD: position 0000_0010, clear=1 for 1 cycle -> OutBUS=0001_0000 next edge, state IDLE, with a fresh press required to move.
REQ-032 SHALL cover enable drop: enable=0 while holding right -> no further steps; enable=1 again with the button still held -> a step 2 edges later via IDLE->STEP.
REQ-033 SHALL cover async reset mid-HOLD: assert reset between clock edges -> outputs return to reset values immediately, without waiting for a clock edge.
